// File: rtl/video_pattern_pkg.sv
// Shared types, constants and helpers for the programmable HDMI test-pattern source.
package video_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_SOLID   = 3'd0,
        MODE_BARS    = 3'd1,
        MODE_RAMP    = 3'd2,
        MODE_CHECKER = 3'd3,
        MODE_MOVBAR  = 3'd4
    } mode_e;

    localparam int unsigned NUM_BARS    = 8;
    localparam int unsigned MOVBAR_STEP = 4;
    localparam int unsigned MOVBAR_W    = 16;

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // h counter is at least 6 bits (checker uses bit 5) and PIXEL_W bits (ramp slice)
    function automatic int unsigned hcnt_w(input int unsigned total, input int unsigned pixel_w);
        int unsigned w;
        w = $clog2(total);
        if (w < 6) w = 6;
        if (w < pixel_w) w = pixel_w;
        return w;
    endfunction

    function automatic int unsigned vcnt_w(input int unsigned total);
        int unsigned w;
        w = $clog2(total);
        if (w < 6) w = 6;
        return w;
    endfunction

    // Bar colour table as {R,G,B} full-scale flags; caller replicates each to PIXEL_W bits
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster h/v counters with combinational de/hsync/vsync decode and line/frame end flags.
module video_timing_counter
    import video_pattern_pkg::*;
#(
    parameter int unsigned PIXEL_W  = 12,
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BP     = 148,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 36,
    parameter int unsigned HS_POL   = 1,
    parameter int unsigned VS_POL   = 1,
    localparam int unsigned HCW = hcnt_w(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP), PIXEL_W),
    localparam int unsigned VCW = vcnt_w(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic           i_clk,
    input  logic           i_rst,
    output logic [HCW-1:0] o_h_c,
    output logic [VCW-1:0] o_v_c,
    output logic           o_de_c,
    output logic           o_hs_c,
    output logic           o_vs_c,
    output logic           o_line_end_c,
    output logic           o_frame_end_c
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT    = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] HS_START = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT    = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] VS_START = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic           HS_ON    = 1'(HS_POL);
    localparam logic           VS_ON    = 1'(VS_POL);

    logic [HCW-1:0] r_h;
    logic [VCW-1:0] r_v;
    logic           w_line_end;

    assign w_line_end = (r_h == H_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_line_end) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + VCW'(1);
        end else begin
            r_h <= r_h + HCW'(1);
        end
    end

    // vsync depends on v only, so it naturally changes at h==0
    assign o_h_c         = r_h;
    assign o_v_c         = r_v;
    assign o_line_end_c  = w_line_end;
    assign o_frame_end_c = w_line_end && (r_v == V_LAST);
    assign o_de_c        = (r_h < H_ACT) && (r_v < V_ACT);
    assign o_hs_c        = ((r_h >= HS_START) && (r_h < HS_END)) ? HS_ON : ~HS_ON;
    assign o_vs_c        = ((r_v >= VS_START) && (r_v < VS_END)) ? VS_ON : ~VS_ON;

endmodule

// File: rtl/video_pattern_gen.sv
// Programmable raster + test-pattern source for the ADV7511 bus; mode changes land on frame boundaries.
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int unsigned PIXEL_W  = 12,
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BP     = 148,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 36,
    parameter int unsigned HS_POL   = 1,
    parameter int unsigned VS_POL   = 1,
    parameter int unsigned FCNT_W   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 setMode__ENA,
    input  logic [2:0]           setMode_mode,
    input  logic [3*PIXEL_W-1:0] setMode_color,
    output logic                 setMode__RDY,
    output logic [3*PIXEL_W-1:0] adv7511_d,
    output logic                 adv7511_de,
    output logic                 adv7511_hs,
    output logic                 adv7511_vs,
    output logic                 frameStart,
    output logic [FCNT_W-1:0]    frameCount
);

    localparam int unsigned HCW   = hcnt_w(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP), PIXEL_W);
    localparam int unsigned VCW   = vcnt_w(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int unsigned HXW   = HCW + 1;
    localparam int unsigned CW    = 3 * PIXEL_W;
    localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

    localparam logic [HCW-1:0] BAR_W_C   = HCW'(BAR_W);
    localparam logic [HXW-1:0] H_ACT_X   = HXW'(H_ACTIVE);
    localparam logic [HXW-1:0] MB_STEP_X = HXW'(MOVBAR_STEP);
    localparam logic [HXW-1:0] MB_W_X    = HXW'(MOVBAR_W);
    localparam logic           HS_ON     = 1'(HS_POL);
    localparam logic           VS_ON     = 1'(VS_POL);

    logic [HCW-1:0] w_h;
    logic [VCW-1:0] w_v;
    logic           w_de, w_hs, w_vs, w_line_end, w_frame_end, w_first_pix;
    logic [CW-1:0]  w_pix;
    logic [2:0]     w_bar_rgb;
    logic           w_in_movbar;
    logic [HXW-1:0] w_bar_x_adv;

    logic [2:0]        r_active_mode, r_shadow_mode;
    logic [CW-1:0]     r_active_color, r_shadow_color;
    logic              r_pending, r_rdy;
    logic [2:0]        r_bar_idx;
    logic [HCW-1:0]    r_bar_bound;
    logic [HCW-1:0]    r_bar_x;
    logic [CW-1:0]     r_d;
    logic              r_de, r_hs, r_vs, r_fs;
    logic [FCNT_W-1:0] r_fcnt;

    video_timing_counter #(
        .PIXEL_W (PIXEL_W),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL  (HS_POL),   .VS_POL(VS_POL)
    ) u_timing (
        .i_clk        (CLK),
        .i_rst        (RST),
        .o_h_c        (w_h),
        .o_v_c        (w_v),
        .o_de_c       (w_de),
        .o_hs_c       (w_hs),
        .o_vs_c       (w_vs),
        .o_line_end_c (w_line_end),
        .o_frame_end_c(w_frame_end)
    );

    assign w_first_pix = (w_h == '0) && (w_v == '0);

    // Shadow/active mode registers; apply and accept are mutually exclusive via r_pending
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_active_mode  <= '0;
            r_active_color <= '0;
            r_shadow_mode  <= '0;
            r_shadow_color <= '0;
            r_pending      <= 1'b0;
            r_rdy          <= 1'b1;
        end else if (w_frame_end && r_pending) begin
            r_active_mode  <= r_shadow_mode;
            r_active_color <= r_shadow_color;
            r_pending      <= 1'b0;
            r_rdy          <= 1'b1;
        end else if (setMode__ENA && !r_pending) begin
            r_shadow_mode  <= setMode_mode;
            r_shadow_color <= setMode_color;
            r_pending      <= 1'b1;
            r_rdy          <= 1'b0;
        end
    end

    // Bar index tracks the current h by stepping at running boundaries; last bar takes the remainder
    always_ff @(posedge CLK or posedge RST) begin
        if (RST || w_line_end) begin
            r_bar_idx   <= '0;
            r_bar_bound <= BAR_W_C;
        end else if ((r_bar_idx != 3'd7) && ((w_h + HCW'(1)) == r_bar_bound)) begin
            r_bar_idx   <= r_bar_idx + 3'd1;
            r_bar_bound <= r_bar_bound + BAR_W_C;
        end
    end

    assign w_bar_x_adv = HXW'(r_bar_x) + MB_STEP_X;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bar_x <= '0;
        end else if (w_frame_end) begin
            r_bar_x <= (w_bar_x_adv >= H_ACT_X) ? '0 : HCW'(w_bar_x_adv);
        end
    end

    assign w_bar_rgb   = bar_rgb(r_bar_idx);
    assign w_in_movbar = (HXW'(w_h) >= HXW'(r_bar_x)) && (HXW'(w_h) < (HXW'(r_bar_x) + MB_W_X));

    always_comb begin
        w_pix = '0;
        if (w_de) begin
            case (r_active_mode)
                MODE_SOLID:   w_pix = r_active_color;
                MODE_BARS:    w_pix = {{PIXEL_W{w_bar_rgb[2]}}, {PIXEL_W{w_bar_rgb[1]}},
                                       {PIXEL_W{w_bar_rgb[0]}}};
                MODE_RAMP:    w_pix = {3{w_h[PIXEL_W-1:0]}};
                MODE_CHECKER: w_pix = (w_h[5] ^ w_v[5]) ? '1 : '0;
                MODE_MOVBAR:  w_pix = w_in_movbar ? '1 : r_active_color;
                default:      w_pix = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_d    <= '0;
            r_de   <= 1'b0;
            r_hs   <= ~HS_ON;
            r_vs   <= ~VS_ON;
            r_fs   <= 1'b0;
            r_fcnt <= '0;
        end else begin
            r_d  <= w_pix;
            r_de <= w_de;
            r_hs <= w_hs;
            r_vs <= w_vs;
            r_fs <= w_first_pix;
            if (w_frame_end) r_fcnt <= r_fcnt + FCNT_W'(1);
        end
    end

    assign setMode__RDY = r_rdy;
    assign adv7511_d    = r_d;
    assign adv7511_de   = r_de;
    assign adv7511_hs   = r_hs;
    assign adv7511_vs   = r_vs;
    assign frameStart   = r_fs;
    assign frameCount   = r_fcnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench: two small-raster instances checked cycle by cycle against a frame-level arithmetic model.
module tb_video_pattern_gen;

    logic        clk;
    logic        rst_a, rst_b;
    logic        ena;
    logic [2:0]  mode;
    logic [35:0] color;

    logic        rdy_a, de_a, hs_a, vs_a, fs_a;
    logic [35:0] d_a;
    logic [15:0] fc_a;
    logic        rdy_b, de_b, hs_b, vs_b, fs_b;
    logic [35:0] d_b;
    logic [15:0] fc_b;

    int checks = 0;
    int errors = 0;

    // Model state: one pending write, applied from pend_frame onward
    bit          sel;
    int          cyc;
    int          act_mode;
    logic [35:0] act_color;
    bit          pend_valid;
    int          pend_mode;
    logic [35:0] pend_color;
    int          pend_frame;

    video_pattern_gen #(
        .PIXEL_W(12), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .FCNT_W(16)
    ) dut_a (
        .CLK(clk), .RST(rst_a),
        .setMode__ENA(ena), .setMode_mode(mode), .setMode_color(color),
        .setMode__RDY(rdy_a),
        .adv7511_d(d_a), .adv7511_de(de_a), .adv7511_hs(hs_a), .adv7511_vs(vs_a),
        .frameStart(fs_a), .frameCount(fc_a)
    );

    video_pattern_gen #(
        .PIXEL_W(12), .H_ACTIVE(64), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .FCNT_W(16)
    ) dut_b (
        .CLK(clk), .RST(rst_b),
        .setMode__ENA(ena), .setMode_mode(mode), .setMode_color(color),
        .setMode__RDY(rdy_b),
        .adv7511_d(d_b), .adv7511_de(de_b), .adv7511_hs(hs_b), .adv7511_vs(vs_b),
        .frameStart(fs_b), .frameCount(fc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [35:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    // Pixel value from the pattern rules, using division instead of any counter scheme
    function automatic logic [35:0] exp_pix(input int m, input logic [35:0] col, input int h,
                                            input int v, input int bx, input int ha);
        logic [35:0] bars [8];
        logic [11:0] r;
        int          idx;
        bars = '{36'hFFFFFFFFF, 36'hFFFFFF000, 36'h000FFFFFF, 36'h000FFF000,
                 36'hFFF000FFF, 36'hFFF000000, 36'h000000FFF, 36'h000000000};
        if (h >= ha || v >= 4) return '0;
        case (m)
            0: return col;
            1: begin
                idx = h / (ha / 8);
                if (idx > 7) idx = 7;
                return bars[idx];
            end
            2: begin
                r = 12'(h);
                return {r, r, r};
            end
            3: return ((((h / 32) % 2) ^ ((v / 32) % 2)) != 0) ? '1 : '0;
            4: return (h >= bx && h < bx + 16) ? '1 : col;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset(input bit s);
        sel        = s;
        cyc        = 0;
        act_mode   = 0;
        act_color  = '0;
        pend_valid = 1'b0;
        pend_mode  = 0;
        pend_color = '0;
        pend_frame = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_d"},    d_a, 36'h0);
        chk({tag, "_de"},   36'(de_a), 36'h0);
        chk({tag, "_hs"},   36'(hs_a), 36'h0);
        chk({tag, "_vs"},   36'(vs_a), 36'h0);
        chk({tag, "_fs"},   36'(fs_a), 36'h0);
        chk({tag, "_fcnt"}, 36'(fc_a), 36'h0);
        chk({tag, "_rdy"},  36'(rdy_a), 36'h1);
    endtask

    // One clock: drive inputs for the current raster cycle, then check the registered outputs
    task automatic tick(input bit e, input logic [2:0] m, input logic [35:0] col);
        int ha, ht, ft, pos, h, v, f, f1, np, bx;
        logic [35:0] o_d;
        logic        o_de, o_hs, o_vs, o_fs, o_rdy;
        logic [15:0] o_fc;
        ena   = e;
        mode  = m;
        color = col;
        @(posedge clk);
        #1;
        ha  = sel ? 64 : 16;
        ht  = ha + 8;
        ft  = ht * 7;
        pos = cyc % ft;
        h   = pos % ht;
        v   = pos / ht;
        f   = cyc / ft;
        f1  = (cyc + 1) / ft;
        if (pend_valid && f >= pend_frame) begin
            act_mode   = pend_mode;
            act_color  = pend_color;
            pend_valid = 1'b0;
        end
        if (e && !pend_valid) begin
            pend_valid = 1'b1;
            pend_mode  = int'(m);
            pend_color = col;
            pend_frame = f1 + 1;
        end
        np = (ha + 3) / 4;
        bx = 4 * (f % np);
        if (sel) begin
            o_d = d_b; o_de = de_b; o_hs = hs_b; o_vs = vs_b; o_fs = fs_b; o_rdy = rdy_b; o_fc = fc_b;
        end else begin
            o_d = d_a; o_de = de_a; o_hs = hs_a; o_vs = vs_a; o_fs = fs_a; o_rdy = rdy_a; o_fc = fc_a;
        end
        chk("pixel", o_d, exp_pix(act_mode, act_color, h, v, bx, ha));
        chk("de",    36'(o_de), 36'((h < ha && v < 4) ? 1 : 0));
        chk("hs",    36'(o_hs), 36'((h >= ha + 2 && h < ha + 5) ? 1 : 0));
        chk("vs",    36'(o_vs), 36'((v == 5) ? 1 : 0));
        chk("fstart", 36'(o_fs), 36'((pos == 0) ? 1 : 0));
        chk("rdy",   36'(o_rdy), 36'((pend_valid && pend_frame > f1) ? 0 : 1));
        chk("fcount", 36'(o_fc), 36'(16'(f1)));
        cyc++;
    endtask

    initial begin
        ena   = 1'b0;
        mode  = '0;
        color = '0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        model_reset(1'b0);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_reset_vals("reset");
        end
        @(negedge clk);
        rst_a = 1'b0;
        model_reset(1'b0);

        // Deferred mode write at h=5,v=1, then ignored writes while not ready
        repeat (29) tick(1'b0, 3'd0, '0);
        tick(1'b1, 3'd1, rnd36());
        chk("rdy_drop", 36'(rdy_a), 36'h0);
        repeat (3) tick(1'b1, 3'd3, rnd36());
        while (cyc < 168) tick(1'b0, 3'd0, '0);
        chk("rdy_back", 36'(rdy_a), 36'h1);
        tick(1'b0, 3'd0, '0);
        chk("bar0_white", d_a, 36'hFFFFFFFFF);
        repeat (2) tick(1'b0, 3'd0, '0);
        chk("bar1_yellow", d_a, 36'hFFFFFF000);
        while (cyc < 2 * 168) tick(1'b0, 3'd0, '0);

        // Random mode traffic over several frames
        repeat (168 * 8) tick(($urandom_range(0, 29) == 0), 3'($urandom_range(0, 7)), rnd36());

        // Reset at h=10,v=2 with a write pending
        while ((cyc % 168) != 40) tick(1'b0, 3'd0, '0);
        tick(1'b1, 3'd2, rnd36());
        while ((cyc % 168) != 58) tick(1'b0, 3'd0, '0);
        chk("rdy_pending", 36'(rdy_a), 36'h0);
        #2;
        rst_a = 1'b1;
        #1;
        chk_reset_vals("midreset");
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        model_reset(1'b0);
        tick(1'b0, 3'd0, '0);
        chk("restart_fs", 36'(fs_a), 36'h1);
        repeat (168 - 1) tick(1'b0, 3'd0, '0);
        repeat (168 * 2) tick(($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)), rnd36());

        // Moving bar on the 64-pixel raster across the wrap of bar_x
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        model_reset(1'b1);
        tick(1'b1, 3'd4, rnd36() & 36'h7FF7FF7FF);
        while (cyc < 504 * 18) begin
            tick(1'b0, 3'd0, '0);
            if (cyc == 15 * 504 + 61) chk("movbar60", d_b, 36'hFFFFFFFFF);
            if (cyc == 16 * 504 + 1)  chk("movbar_wrap", d_b, 36'hFFFFFFFFF);
            if (cyc == 16 * 504 + 17) chk("movbar_after", d_b, act_color);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
